// File: rtl/ysyx_23060240_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_seq_ctrl_pkg
//   Shared definitions for the multi-cycle instruction sequencer:
//   - state_e      : sequencer phases FETCH / EXEC / MEM / HALT
//   - halt_code_e  : reason the core stopped (reported on halt_code)
//   - RESET_PC_DEFAULT, NOP_INST : reset values for pc and inst
//   - is_misaligned : jump-target alignment test used in EXEC
// ---------------------------------------------------------------------------
package ysyx_23060240_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    HALT_RUN      = 3'd0,
    HALT_EBREAK   = 3'd1,
    HALT_BUS_ERR  = 3'd2,
    HALT_TIMEOUT  = 3'd3,
    HALT_ILLEGAL  = 3'd4,
    HALT_MISALIGN = 3'd5
  } halt_code_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Only word alignment is enforced; compressed instructions are not supported.
  function automatic logic is_misaligned(input logic [31:0] target);
    return target[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060240_wdt.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_wdt
//   Handshake timeout counter for the sequencer.
//   Ports:
//     clk, rst  : clock, asynchronous active-low reset
//     clr       : synchronous clear, asserted on every sequencer state change
//     en        : count this cycle (a request is being held)
//     expire    : combinational; high in the TMO_CYC-th counted cycle
// ---------------------------------------------------------------------------
module ysyx_23060240_wdt #(
  parameter int TMO_CYC = 1024,
  parameter int TMO_W   = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  // The count is the number of cycles already spent waiting; clearing on
  // state entry means the first waiting cycle sees zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // Expiry is flagged during the last allowed cycle so the owner can still
  // let a same-cycle completion take priority over the timeout.
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ysyx_23060240_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_seq_ctrl
//   Multi-cycle sequencer: owns pc and the instruction register, steps
//   FETCH -> EXEC -> (MEM) -> FETCH, emits the commit pulse and halts the
//   core on ebreak, bus error, illegal opcode, misaligned jump or timeout.
//   Ports:
//     clk, rst                         : clock, asynchronous active-low reset
//     fetch_req/fetch_pc               : level request to IFU, address = pc
//     fetch_done/fetch_err/inst_in     : IFU response
//     inst                             : latched instruction for IDU
//     dec_mem_rd/wr, dec_ebreak,
//     dec_illegal, jump_en, jump_pc    : decode results, valid in EXEC
//     lsu_rd_req/lsu_wr_req            : level requests to LSU
//     lsu_done/lsu_err                 : LSU response
//     commit                           : one-cycle retire strobe
//     pc, halt, halt_code, instret     : architectural status
// ---------------------------------------------------------------------------
module ysyx_23060240_seq_ctrl
  import ysyx_23060240_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TMO_CYC  = 1024,
  parameter int          TMO_W    = 11
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_pc,
  input  logic        fetch_done,
  input  logic        fetch_err,
  input  logic [31:0] inst_in,
  output logic [31:0] inst,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        lsu_rd_req,
  output logic        lsu_wr_req,
  input  logic        lsu_done,
  input  logic        lsu_err,
  output logic        commit,
  output logic [31:0] pc,
  output logic        halt,
  output logic [2:0]  halt_code,
  output logic [63:0] instret
);

  state_e     state;
  state_e     state_nxt;
  halt_code_e halt_code_q;
  halt_code_e code_nxt;
  logic       wdt_clr;
  logic       wdt_en;
  logic       wdt_expire;

  // The timeout only runs while a request is actually on the bus. Right
  // after reset the FETCH state is entered with fetch_req still low, so that
  // first cycle is neither counted nor allowed to accept a response.
  assign wdt_en  = (state == ST_FETCH && fetch_req) || (state == ST_MEM);
  assign wdt_clr = (state_nxt != state);

  ysyx_23060240_wdt #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdt_clr),
    .en     (wdt_en),
    .expire (wdt_expire)
  );

  // Next-state and commit decision. Commit has to be combinational: in EXEC
  // the decode results depend on the freshly latched inst, and in MEM the
  // retire must line up with lsu_done so load data is written that cycle.
  always_comb begin
    state_nxt = state;
    code_nxt  = HALT_RUN;
    commit    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (fetch_req) begin
          if (fetch_err) begin
            state_nxt = ST_HALT;
            code_nxt  = HALT_BUS_ERR;
          end else if (fetch_done) begin
            state_nxt = ST_EXEC;
          end else if (wdt_expire) begin
            state_nxt = ST_HALT;
            code_nxt  = HALT_TIMEOUT;
          end
        end
      end
      ST_EXEC: begin
        if (dec_illegal) begin
          state_nxt = ST_HALT;
          code_nxt  = HALT_ILLEGAL;
        end else if (dec_ebreak) begin
          state_nxt = ST_HALT;
          code_nxt  = HALT_EBREAK;
        end else if (jump_en && is_misaligned(jump_pc)) begin
          state_nxt = ST_HALT;
          code_nxt  = HALT_MISALIGN;
        end else if (dec_mem_rd || dec_mem_wr) begin
          state_nxt = ST_MEM;
        end else begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (lsu_err) begin
          state_nxt = ST_HALT;
          code_nxt  = HALT_BUS_ERR;
        end else if (lsu_done) begin
          commit    = 1'b1;
          state_nxt = ST_FETCH;
        end else if (wdt_expire) begin
          state_nxt = ST_HALT;
          code_nxt  = HALT_TIMEOUT;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // Single state/datapath register block. Requests are registered from the
  // next state, so a request appears the cycle after the decision and drops
  // together with the state change. While in MEM the access direction chosen
  // at EXEC is simply held; a load wins when decode flags both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      instret     <= '0;
      halt        <= 1'b0;
      halt_code_q <= HALT_RUN;
      fetch_req   <= 1'b0;
      lsu_rd_req  <= 1'b0;
      lsu_wr_req  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_req  <= (state_nxt == ST_FETCH);
      lsu_rd_req <= (state_nxt == ST_MEM) && ((state == ST_MEM) ? lsu_rd_req : dec_mem_rd);
      lsu_wr_req <= (state_nxt == ST_MEM) && ((state == ST_MEM) ? lsu_wr_req : !dec_mem_rd);
      if (state == ST_FETCH && state_nxt == ST_EXEC) begin
        inst <= inst_in;
      end
      if (commit) begin
        pc      <= (state == ST_EXEC && jump_en) ? jump_pc : pc + 32'd4;
        instret <= instret + 64'd1;
      end
      if (state != ST_HALT && state_nxt == ST_HALT) begin
        halt        <= 1'b1;
        halt_code_q <= code_nxt;
      end
    end
  end

  assign fetch_pc  = pc;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_ysyx_23060240_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060240_seq_ctrl
//   Drives whole instruction transactions into the sequencer and compares
//   against an instruction-level model: each transaction is described by its
//   fetch latency, decode flags and LSU latency, and the model derives the
//   retire/halt outcome, next pc and instret directly from those.
// ---------------------------------------------------------------------------
module tb_ysyx_23060240_seq_ctrl;

  localparam int          TMO = 8;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_done = 1'b0;
  logic        fetch_err = 1'b0;
  logic [31:0] inst_in = '0;
  logic [31:0] inst;
  logic        dec_mem_rd = 1'b0;
  logic        dec_mem_wr = 1'b0;
  logic        dec_ebreak = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        lsu_rd_req;
  logic        lsu_wr_req;
  logic        lsu_done = 1'b0;
  logic        lsu_err = 1'b0;
  logic        commit;
  logic [31:0] pc;
  logic        halt;
  logic [2:0]  halt_code;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [63:0] exp_instret;
  bit          halted;
  logic        prev_commit = 1'b0;

  typedef struct packed {
    logic [7:0]  fetch_lat;
    logic        f_err;
    logic [31:0] ins;
    logic        illegal;
    logic        ebreak;
    logic        jump;
    logic [31:0] jpc;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  lsu_lat;
    logic        l_err;
  } instr_t;

  always #5 clk = ~clk;

  ysyx_23060240_seq_ctrl #(
    .RESET_PC (RPC),
    .TMO_CYC  (TMO),
    .TMO_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_done  (fetch_done),
    .fetch_err   (fetch_err),
    .inst_in     (inst_in),
    .inst        (inst),
    .dec_mem_rd  (dec_mem_rd),
    .dec_mem_wr  (dec_mem_wr),
    .dec_ebreak  (dec_ebreak),
    .dec_illegal (dec_illegal),
    .jump_en     (jump_en),
    .jump_pc     (jump_pc),
    .lsu_rd_req  (lsu_rd_req),
    .lsu_wr_req  (lsu_wr_req),
    .lsu_done    (lsu_done),
    .lsu_err     (lsu_err),
    .commit      (commit),
    .pc          (pc),
    .halt        (halt),
    .halt_code   (halt_code),
    .instret     (instret)
  );

  // Bus invariants sampled mid-cycle: requests mutually exclusive and commit
  // never asserted in two consecutive cycles.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      assert ($countones({fetch_req, lsu_rd_req, lsu_wr_req}) <= 1)
      else begin
        errors++;
        $error("[TB] FAIL req_onehot: observed %b expected at most one set", {fetch_req, lsu_rd_req, lsu_wr_req});
      end
      checks++;
      assert (!(commit && prev_commit))
      else begin
        errors++;
        $error("[TB] FAIL commit_twice: observed 1 expected 0");
      end
      prev_commit = commit;
    end else begin
      prev_commit = 1'b0;
    end
  end

  // Hard stop in case the design wedges somewhere the bounded loops miss.
  initial begin
    #500_000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t plainInstr(input logic [31:0] ins, input int flat);
    instr_t t;
    t           = '0;
    t.ins       = ins;
    t.fetch_lat = 8'(flat);
    return t;
  endfunction

  // Reset held across a clock edge, reset values checked, then released on a
  // falling edge so fetch_req must rise on the very next rising edge.
  task automatic doReset();
    rst = 1'b0;
    fetch_done = 1'b0; fetch_err = 1'b0; lsu_done = 1'b0; lsu_err = 1'b0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
    jump_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pc", pc, RPC);
    checkOutput("rst_fetch_pc", fetch_pc, RPC);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_instret", instret, 64'd0);
    checkOutput("rst_halt", halt, 0);
    checkOutput("rst_code", halt_code, 0);
    checkOutput("rst_reqs", {fetch_req, lsu_rd_req, lsu_wr_req}, 0);
    checkOutput("rst_commit", commit, 0);
    rst = 1'b1;
    #1;
    checkOutput("fetch_req_before_edge", fetch_req, 0);
    @(posedge clk);
    #1;
    checkOutput("fetch_req_first_edge", fetch_req, 1);
    exp_pc      = RPC;
    exp_instret = 64'd0;
    halted      = 1'b0;
  endtask

  task automatic finishHalt(input logic [2:0] code);
    checkOutput("halt", halt, 1);
    checkOutput("halt_code", halt_code, {61'd0, code});
    checkOutput("halt_reqs", {fetch_req, lsu_rd_req, lsu_wr_req}, 0);
    checkOutput("halt_pc", pc, exp_pc);
    checkOutput("halt_instret", instret, exp_instret);
    tick();
    checkOutput("halt_sticky", {halt, fetch_req, commit}, 3'b100);
    halted = 1'b1;
  endtask

  // One full transaction starting in a FETCH cycle with fetch_req high.
  task automatic applyStimulus(input instr_t t);
    logic [2:0] code;
    bit         go_mem;
    bit         plain;
    for (int c = 0; c < TMO; c++) begin
      checkOutput("fetch_req", fetch_req, 1);
      checkOutput("fetch_pc", fetch_pc, exp_pc);
      checkOutput("no_early_halt", halt, 0);
      if (c == int'(t.fetch_lat)) begin
        fetch_done = 1'b1;
        fetch_err  = t.f_err;
        inst_in    = t.ins;
      end
      #1;
      checkOutput("commit_in_fetch", commit, 0);
      tick();
      fetch_done = 1'b0;
      fetch_err  = 1'b0;
      inst_in    = $urandom;
      if (c == int'(t.fetch_lat)) break;
    end
    if (int'(t.fetch_lat) > TMO - 1) begin finishHalt(3'd3); return; end
    if (t.f_err) begin finishHalt(3'd2); return; end

    checkOutput("inst", inst, t.ins);
    checkOutput("exec_no_req", {fetch_req, lsu_rd_req, lsu_wr_req}, 0);
    if (t.illegal) code = 3'd4;
    else if (t.ebreak) code = 3'd1;
    else if (t.jump && t.jpc[1:0] != 2'b00) code = 3'd5;
    else code = 3'd0;
    go_mem = (code == 3'd0) && (t.mem_rd || t.mem_wr);
    plain  = (code == 3'd0) && !go_mem;
    dec_illegal = t.illegal;
    dec_ebreak  = t.ebreak;
    jump_en     = t.jump;
    jump_pc     = t.jpc;
    dec_mem_rd  = t.mem_rd;
    dec_mem_wr  = t.mem_wr;
    #1;
    checkOutput("commit_exec", commit, plain);
    tick();
    dec_illegal = 1'b0; dec_ebreak = 1'b0; jump_en = 1'b0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0;
    if (code != 3'd0) begin finishHalt(code); return; end
    if (plain) begin
      exp_pc      = t.jump ? t.jpc : exp_pc + 32'd4;
      exp_instret = exp_instret + 64'd1;
      checkOutput("plain_pc", pc, exp_pc);
      checkOutput("plain_instret", instret, exp_instret);
      checkOutput("plain_next_fetch", fetch_req, 1);
      return;
    end

    for (int c = 0; c < TMO; c++) begin
      checkOutput("lsu_rd_req", lsu_rd_req, t.mem_rd);
      checkOutput("lsu_wr_req", lsu_wr_req, !t.mem_rd);
      checkOutput("mem_fetch_req", fetch_req, 0);
      if (c == int'(t.lsu_lat)) begin
        lsu_done = 1'b1;
        lsu_err  = t.l_err;
      end
      #1;
      checkOutput("commit_mem", commit, (c == int'(t.lsu_lat)) && !t.l_err);
      tick();
      lsu_done = 1'b0;
      lsu_err  = 1'b0;
      if (c == int'(t.lsu_lat)) break;
    end
    if (int'(t.lsu_lat) > TMO - 1) begin finishHalt(3'd3); return; end
    if (t.l_err) begin finishHalt(3'd2); return; end
    exp_pc      = exp_pc + 32'd4;
    exp_instret = exp_instret + 64'd1;
    checkOutput("mem_pc", pc, exp_pc);
    checkOutput("mem_instret", instret, exp_instret);
    checkOutput("mem_req_drop", {lsu_rd_req, lsu_wr_req}, 0);
    checkOutput("mem_next_fetch", fetch_req, 1);
  endtask

  // Get a load into MEM, then pull reset in the middle of the cycle: the
  // request and pc must fall back without waiting for a clock edge.
  task automatic resetMidMem();
    fetch_done = 1'b1;
    inst_in    = 32'h0001_2083;
    tick();
    fetch_done = 1'b0;
    dec_mem_rd = 1'b1;
    tick();
    dec_mem_rd = 1'b0;
    checkOutput("mid_mem_req", lsu_rd_req, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_reqs", {fetch_req, lsu_rd_req, lsu_wr_req}, 0);
    checkOutput("async_rst_pc", pc, RPC);
    checkOutput("async_rst_commit", commit, 0);
  endtask

  initial begin
    instr_t t;
    int     r;
    $display("[TB] start");
    doReset();

    applyStimulus(plainInstr(32'h0010_0093, 3));

    t = plainInstr(32'h0f00_006f, 0); t.jump = 1'b1; t.jpc = 32'h8000_0100;
    applyStimulus(t);
    t = plainInstr(32'h0020_006f, 1); t.jump = 1'b1; t.jpc = 32'h8000_0102;
    applyStimulus(t);
    doReset();

    t = plainInstr(32'h0001_2083, 1); t.mem_rd = 1'b1; t.lsu_lat = 8'd5;
    applyStimulus(t);

    t = plainInstr(32'h0010_0093, 2); t.f_err = 1'b1;
    applyStimulus(t);
    doReset();
    applyStimulus(plainInstr(32'h0010_0093, 0));
    t = plainInstr(32'h0011_2023, 1); t.mem_wr = 1'b1; t.lsu_lat = 8'd2; t.l_err = 1'b1;
    applyStimulus(t);
    doReset();

    applyStimulus(plainInstr(32'h0010_0093, 20));
    doReset();
    t = plainInstr(32'h0001_2083, 0); t.mem_rd = 1'b1; t.lsu_lat = 8'd7;
    applyStimulus(t);
    t = plainInstr(32'h0011_2023, 7); t.mem_wr = 1'b1; t.lsu_lat = 8'd20;
    applyStimulus(t);
    doReset();

    t = plainInstr(32'hffff_ffff, 0); t.illegal = 1'b1; t.ebreak = 1'b1;
    applyStimulus(t);
    doReset();

    t = plainInstr(32'h0001_2083, 0); t.mem_rd = 1'b1; t.mem_wr = 1'b1; t.lsu_lat = 8'd0;
    applyStimulus(t);
    t = plainInstr(32'h0000_006f, 0); t.jump = 1'b1; t.jpc = 32'hffff_fffc;
    applyStimulus(t);
    applyStimulus(plainInstr(32'h0010_0093, 0));

    doReset();
    applyStimulus(plainInstr(32'h0010_0093, 1));
    t = plainInstr(32'h0010_0073, 0); t.ebreak = 1'b1;
    applyStimulus(t);
    doReset();

    applyStimulus(plainInstr(32'h0010_0093, 0));
    resetMidMem();
    doReset();

    for (int n = 0; n < 60; n++) begin
      t         = plainInstr($urandom, int'($urandom_range(0, 8)));
      t.f_err   = ($urandom_range(0, 19) == 0);
      t.illegal = ($urandom_range(0, 15) == 0);
      t.ebreak  = ($urandom_range(0, 15) == 0);
      t.jump    = ($urandom_range(0, 3) == 0);
      t.jpc     = ($urandom & 32'hffff_fffc) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      r         = int'($urandom_range(0, 5));
      t.mem_rd  = (r == 0) || (r == 2);
      t.mem_wr  = (r == 1) || (r == 2);
      t.lsu_lat = 8'($urandom_range(0, 8));
      t.l_err   = ($urandom_range(0, 19) == 0);
      applyStimulus(t);
      if (halted) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
